// File: rtl/pkt_slot_responder_pkg.sv
// Shared definitions for the single-packet slot: FSM encoding, EOP rule and depth-derived levels.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package pkt_slot_responder_pkg;

   // FSM encoding, kept as plain constants so older tools and wave viewers show raw codes.
   localparam logic [1:0] ST_EMPTY   = 2'd0;
   localparam logic [1:0] ST_WRITING = 2'd1;
   localparam logic [1:0] ST_HOLD    = 2'd2;
   localparam logic [1:0] ST_READING = 2'd3;

   // Widest control word the EOP helper accepts; narrower words are zero-extended.
   localparam int unsigned MAX_CTRL_WIDTH = 64;

   // Occupancy at or below which the slot reports nearly_empty.
   localparam int unsigned NEARLY_EMPTY_LEVEL = 1;

   function automatic int unsigned slot_depth(input int unsigned addr_width);
      return 32'd1 << addr_width;
   endfunction

   function automatic int unsigned nearly_full_level(input int unsigned addr_width);
      return slot_depth(addr_width) - 1;
   endfunction

   // A word ends the packet when it carries control while the word before it was plain data.
   function automatic logic is_eop(input logic [MAX_CTRL_WIDTH-1:0] ctrl,
                                   input logic                      prev_ctrl_zero);
      return (ctrl != '0) && prev_ctrl_zero;
   endfunction

endpackage

// File: rtl/pkt_slot_ram.sv
// Packet storage for one slot: simple dual-port RAM, one write port, one read port.
// Latency: write lands on the clock edge, read data is combinational from the address.
// Backpressure: none; the caller decides when to write and which address to present.
//
// Ports:
//   clk_i    - clock
//   we_i     - write enable, word stored at waddr_i on the rising edge
//   waddr_i  - write address
//   wdata_i  - write word {forced_last, ctrl, data}
//   raddr_i  - read address
//   rdata_o  - word stored at raddr_i
module pkt_slot_ram #(
   parameter int ADDR_WIDTH = 8,
   parameter int WORD_WIDTH = 73
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [WORD_WIDTH-1:0] wdata_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [WORD_WIDTH-1:0] rdata_o
);

   logic [WORD_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

   // Contents are not reset: occupancy is tracked by the owner's counter.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pkt_slot_responder.sv
// Single-packet slot answering the controller's write/read handshake; stores one packet then replays it.
// Latency: grant 1 cycle after request; one word per cycle each way; done pulse 1 cycle after the final word.
// Backpressure: input gated by in_rdy_o (dropped when low); output stalls on out_rdy_i with head word held.
//
// Ports:
//   clk_i, rst_i                    - clock, synchronous active-high reset
//   wr_req_i / wr_ack_o / wr_done_o - write request (level), grant pulse, packet-stored pulse
//   rd_req_i / rd_ack_o / rd_done_o - read request (level), grant pulse, packet-drained pulse
//   pckt_rd_wr_o                    - 1 = slot free for writing, 0 = slot holds a packet
//   in_wr_i, in_rdy_o               - input word valid / slot accepting
//   fifo_data_in_i, fifo_ctrl_in_i  - input word
//   out_rdy_i, out_wr_o             - destination ready / output word valid
//   fifo_data_out_o, fifo_ctrl_out_o- head word while reading, zero otherwise
//   word_count_o                    - words currently stored
//   full_o, empty_o, nearly_full_o, nearly_empty_o - occupancy status
//   trunc_o                         - pulse: packet cut at slot capacity
module pkt_slot_responder
   import pkt_slot_responder_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  wr_req_i,
   input  logic                  rd_req_i,
   output logic                  wr_ack_o,
   output logic                  rd_ack_o,
   output logic                  wr_done_o,
   output logic                  rd_done_o,
   output logic                  pckt_rd_wr_o,
   input  logic                  in_wr_i,
   output logic                  in_rdy_o,
   input  logic [DATA_WIDTH-1:0] fifo_data_in_i,
   input  logic [CTRL_WIDTH-1:0] fifo_ctrl_in_i,
   input  logic                  out_rdy_i,
   output logic                  out_wr_o,
   output logic [DATA_WIDTH-1:0] fifo_data_out_o,
   output logic [CTRL_WIDTH-1:0] fifo_ctrl_out_o,
   output logic [ADDR_WIDTH:0]   word_count_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  nearly_full_o,
   output logic                  nearly_empty_o,
   output logic                  trunc_o
);

   localparam int unsigned DEPTH      = slot_depth(ADDR_WIDTH);
   localparam int          WORD_WIDTH = DATA_WIDTH + CTRL_WIDTH + 1;

   localparam logic [ADDR_WIDTH:0] CNT_FULL   = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] CNT_LAST   = (ADDR_WIDTH+1)'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0] CNT_NFULL  = (ADDR_WIDTH+1)'(nearly_full_level(ADDR_WIDTH));
   localparam logic [ADDR_WIDTH:0] CNT_NEMPTY = (ADDR_WIDTH+1)'(NEARLY_EMPTY_LEVEL);
   localparam logic [ADDR_WIDTH:0] CNT_ONE    = (ADDR_WIDTH+1)'(1);

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic                  prev_zero_q, prev_zero_d;

   logic wr_ack_q, wr_ack_d;
   logic rd_ack_q, rd_ack_d;
   logic wr_done_q, wr_done_d;
   logic rd_done_q, rd_done_d;
   logic trunc_q, trunc_d;
   logic in_rdy_q, in_rdy_d;
   logic pckt_rd_wr_q, pckt_rd_wr_d;
   logic full_q, empty_q, nearly_full_q, nearly_empty_q;

   logic                  wr_fire;
   logic                  word_eop;
   logic                  fills_slot;
   logic                  rd_fire;
   logic                  rd_last;
   logic [WORD_WIDTH-1:0] ram_wdata;
   logic [WORD_WIDTH-1:0] ram_rdata;

   assign wr_fire    = (state_q == ST_WRITING) && in_wr_i && in_rdy_q;
   assign word_eop   = is_eop(MAX_CTRL_WIDTH'(fifo_ctrl_in_i), prev_zero_q);
   assign fills_slot = (cnt_q == CNT_LAST);

   // The top bit marks a word that closes a packet only because the slot ran out of room.
   assign ram_wdata = {fills_slot && !word_eop, fifo_ctrl_in_i, fifo_data_in_i};

   assign out_wr_o = (state_q == ST_READING) && out_rdy_i && (cnt_q != '0);
   assign rd_fire  = out_wr_o;
   assign rd_last  = (cnt_q == CNT_ONE) || ram_rdata[WORD_WIDTH-1];

   pkt_slot_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .WORD_WIDTH (WORD_WIDTH)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (wr_fire),
      .waddr_i (wr_ptr_q),
      .wdata_i (ram_wdata),
      .raddr_i (rd_ptr_q),
      .rdata_o (ram_rdata)
   );

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cnt_d       = cnt_q;
      prev_zero_d = prev_zero_q;
      wr_ack_d    = 1'b0;
      rd_ack_d    = 1'b0;
      wr_done_d   = 1'b0;
      rd_done_d   = 1'b0;
      trunc_d     = 1'b0;

      case (state_q)
         ST_EMPTY: begin
            if (wr_req_i) begin
               wr_ack_d    = 1'b1;
               state_d     = ST_WRITING;
               wr_ptr_d    = '0;
               rd_ptr_d    = '0;
               cnt_d       = '0;
               // The first word has no predecessor, so it can never be an EOP.
               prev_zero_d = 1'b0;
            end
         end
         ST_WRITING: begin
            if (wr_fire) begin
               wr_ptr_d    = wr_ptr_q + 1'b1;
               cnt_d       = cnt_q + 1'b1;
               prev_zero_d = (fifo_ctrl_in_i == '0);
               if (word_eop) begin
                  wr_done_d = 1'b1;
                  state_d   = ST_HOLD;
               end else if (fills_slot) begin
                  trunc_d   = 1'b1;
                  wr_done_d = 1'b1;
                  state_d   = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (rd_req_i) begin
               rd_ack_d = 1'b1;
               rd_ptr_d = '0;
               state_d  = ST_READING;
            end
         end
         ST_READING: begin
            if (rd_fire) begin
               rd_ptr_d = rd_ptr_q + 1'b1;
               cnt_d    = cnt_q - 1'b1;
               if (rd_last) begin
                  rd_done_d = 1'b1;
                  rd_ptr_d  = '0;
                  wr_ptr_d  = '0;
                  cnt_d     = '0;
                  state_d   = ST_EMPTY;
               end
            end
         end
         default: state_d = ST_EMPTY;
      endcase

      // Status is registered from the next-state values so it lines up with the pulses.
      in_rdy_d     = (state_d == ST_WRITING) && (cnt_d != CNT_FULL);
      pckt_rd_wr_d = (state_d == ST_EMPTY) || (state_d == ST_WRITING);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= ST_EMPTY;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         cnt_q          <= '0;
         prev_zero_q    <= 1'b0;
         wr_ack_q       <= 1'b0;
         rd_ack_q       <= 1'b0;
         wr_done_q      <= 1'b0;
         rd_done_q      <= 1'b0;
         trunc_q        <= 1'b0;
         in_rdy_q       <= 1'b0;
         pckt_rd_wr_q   <= 1'b1;
         full_q         <= 1'b0;
         empty_q        <= 1'b1;
         nearly_full_q  <= 1'b0;
         nearly_empty_q <= 1'b1;
      end else begin
         state_q        <= state_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         cnt_q          <= cnt_d;
         prev_zero_q    <= prev_zero_d;
         wr_ack_q       <= wr_ack_d;
         rd_ack_q       <= rd_ack_d;
         wr_done_q      <= wr_done_d;
         rd_done_q      <= rd_done_d;
         trunc_q        <= trunc_d;
         in_rdy_q       <= in_rdy_d;
         pckt_rd_wr_q   <= pckt_rd_wr_d;
         full_q         <= (cnt_d == CNT_FULL);
         empty_q        <= (cnt_d == '0);
         nearly_full_q  <= (cnt_d >= CNT_NFULL);
         nearly_empty_q <= (cnt_d <= CNT_NEMPTY);
      end
   end

   assign wr_ack_o        = wr_ack_q;
   assign rd_ack_o        = rd_ack_q;
   assign wr_done_o       = wr_done_q;
   assign rd_done_o       = rd_done_q;
   assign trunc_o         = trunc_q;
   assign in_rdy_o        = in_rdy_q;
   assign pckt_rd_wr_o    = pckt_rd_wr_q;
   assign word_count_o    = cnt_q;
   assign full_o          = full_q;
   assign empty_o         = empty_q;
   assign nearly_full_o   = nearly_full_q;
   assign nearly_empty_o  = nearly_empty_q;
   assign fifo_data_out_o = (state_q == ST_READING) ? ram_rdata[DATA_WIDTH-1:0] : '0;
   assign fifo_ctrl_out_o = (state_q == ST_READING) ? ram_rdata[DATA_WIDTH +: CTRL_WIDTH] : '0;

endmodule

// File: tb/tb_pkt_slot_responder.sv
// Bench for the single-packet slot, using a 4-word slot so the capacity boundary is reachable.
// Latency: n/a.
// Backpressure: exercised through out_rdy patterns and words offered while the slot refuses them.
module tb_pkt_slot_responder;

   localparam int AW    = 2;
   localparam int DW    = 64;
   localparam int CW    = 8;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_req = 1'b0, rd_req = 1'b0;
   logic          in_wr = 1'b0, out_rdy = 1'b0;
   logic [DW-1:0] din = '0;
   logic [CW-1:0] cin = '0;

   logic          wr_ack, rd_ack, wr_done, rd_done, pckt_rd_wr, in_rdy, out_wr;
   logic [DW-1:0] dout;
   logic [CW-1:0] cout;
   logic [AW:0]   word_count;
   logic          full, empty, nearly_full, nearly_empty, trunc;

   pkt_slot_responder #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .CTRL_WIDTH (CW)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .wr_req_i        (wr_req),
      .rd_req_i        (rd_req),
      .wr_ack_o        (wr_ack),
      .rd_ack_o        (rd_ack),
      .wr_done_o       (wr_done),
      .rd_done_o       (rd_done),
      .pckt_rd_wr_o    (pckt_rd_wr),
      .in_wr_i         (in_wr),
      .in_rdy_o        (in_rdy),
      .fifo_data_in_i  (din),
      .fifo_ctrl_in_i  (cin),
      .out_rdy_i       (out_rdy),
      .out_wr_o        (out_wr),
      .fifo_data_out_o (dout),
      .fifo_ctrl_out_o (cout),
      .word_count_o    (word_count),
      .full_o          (full),
      .empty_o         (empty),
      .nearly_full_o   (nearly_full),
      .nearly_empty_o  (nearly_empty),
      .trunc_o         (trunc)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, wanted %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: a packet queue plus a slot mode ----------------
   typedef struct packed {
      logic [DW-1:0] d;
      logic [CW-1:0] c;
   } word_t;

   word_t mq[$];
   int    m_head = 0;
   int    m_mode = 0;  // 0 free, 1 filling, 2 holding a packet, 3 draining
   bit    m_prev_zero = 1'b0;
   bit    e_wr_ack = 1'b0, e_rd_ack = 1'b0, e_wr_done = 1'b0, e_rd_done = 1'b0, e_trunc = 1'b0;

   always @(posedge clk) begin
      e_wr_ack  = 1'b0;
      e_rd_ack  = 1'b0;
      e_wr_done = 1'b0;
      e_rd_done = 1'b0;
      e_trunc   = 1'b0;
      if (rst) begin
         m_mode = 0;
         mq.delete();
         m_head = 0;
         m_prev_zero = 1'b0;
      end else begin
         case (m_mode)
            0: if (wr_req) begin
                  e_wr_ack = 1'b1;
                  m_mode = 1;
                  mq.delete();
                  m_head = 0;
                  m_prev_zero = 1'b0;
               end
            1: if (in_wr && mq.size() < DEPTH) begin
                  mq.push_back(word_t'{d: din, c: cin});
                  if (cin != 0 && m_prev_zero) begin
                     e_wr_done = 1'b1;
                     m_mode = 2;
                  end else if (mq.size() == DEPTH) begin
                     e_trunc = 1'b1;
                     e_wr_done = 1'b1;
                     m_mode = 2;
                  end
                  m_prev_zero = (cin == 0);
               end
            2: if (rd_req) begin
                  e_rd_ack = 1'b1;
                  m_mode = 3;
                  m_head = 0;
               end
            default: if (out_rdy && m_head < mq.size()) begin
                  m_head++;
                  if (m_head == mq.size()) begin
                     e_rd_done = 1'b1;
                     m_mode = 0;
                     mq.delete();
                     m_head = 0;
                  end
               end
         endcase
      end
   end

   // ---------------- per-cycle compare against the model ----------------
   bit            chk_en = 1'b0;
   logic [DW-1:0] obs[$];
   int            n_wr_ack_seen = 0;
   int            n_rd_ack_seen = 0;

   always @(negedge clk) begin
      int  cnt;
      bit  live;
      if (chk_en) begin
         cnt  = mq.size() - m_head;
         live = (m_mode == 3) && (cnt > 0);
         chk("word_count",   word_count,   cnt);
         chk("empty",        empty,        cnt == 0);
         chk("full",         full,         cnt == DEPTH);
         chk("nearly_full",  nearly_full,  cnt >= DEPTH - 1);
         chk("nearly_empty", nearly_empty, cnt <= 1);
         chk("pckt_rd_wr",   pckt_rd_wr,   m_mode <= 1);
         chk("in_rdy",       in_rdy,       (m_mode == 1) && (cnt < DEPTH));
         chk("wr_ack",       wr_ack,       e_wr_ack);
         chk("rd_ack",       rd_ack,       e_rd_ack);
         chk("wr_done",      wr_done,      e_wr_done);
         chk("rd_done",      rd_done,      e_rd_done);
         chk("trunc",        trunc,        e_trunc);
         chk("out_wr",       out_wr,       live && out_rdy);
         chk("data_out",     dout,         live ? mq[m_head].d : '0);
         chk("ctrl_out",     cout,         live ? 64'(mq[m_head].c) : 64'd0);
         if (out_wr === 1'b1) obs.push_back(dout);
         if (wr_ack === 1'b1) n_wr_ack_seen++;
         if (rd_ack === 1'b1) n_rd_ack_seen++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic grant();
      wr_req = 1'b1;
      step();
      wr_req = 1'b0;
   endtask

   task automatic put(input logic [DW-1:0] d, input logic [CW-1:0] c);
      in_wr = 1'b1;
      din   = d;
      cin   = c;
      step();
      in_wr = 1'b0;
      din   = '0;
      cin   = '0;
   endtask

   task automatic drain(input int n);
      rd_req = 1'b1;
      step();
      rd_req  = 1'b0;
      out_rdy = 1'b1;
      step(n);
      out_rdy = 1'b0;
   endtask

   function automatic logic [DW-1:0] obs_at(input int i);
      return (obs.size() > i) ? obs[i] : 'x;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bit pat[5];
      int w0, r0;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

      step(2);
      chk_en = 1'b1;
      chk("lit_rst_count", word_count, 0);
      chk("lit_rst_pckt",  pckt_rd_wr, 1);
      chk("lit_rst_nempty", nearly_empty, 1);
      rst = 1'b0;
      step();

      // basic write then read
      obs.delete();
      grant();
      chk("lit_basic_ack", wr_ack, 1);
      chk("lit_basic_rdy", in_rdy, 1);
      put(64'hA1, 8'hFF);
      put(64'hA2, 8'h00);
      put(64'hA3, 8'h01);
      chk("lit_basic_done",  wr_done, 1);
      chk("lit_basic_count", word_count, 3);
      chk("lit_basic_pckt",  pckt_rd_wr, 0);
      chk("lit_basic_rdy0",  in_rdy, 0);
      drain(3);
      chk("lit_basic_rdone", rd_done, 1);
      chk("lit_basic_pckt1", pckt_rd_wr, 1);
      chk("lit_basic_dout0", dout, 0);
      chk("lit_basic_n",     obs.size(), 3);
      chk("lit_basic_w0",    obs_at(0), 64'hA1);
      chk("lit_basic_w1",    obs_at(1), 64'hA2);
      chk("lit_basic_w2",    obs_at(2), 64'hA3);

      // read back-pressure
      obs.delete();
      grant();
      put(64'hB1, 8'hFF);
      put(64'hB2, 8'h00);
      put(64'hB3, 8'h01);
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      chk("lit_bp_rdack", rd_ack, 1);
      for (int i = 0; i < 5; i++) begin
         out_rdy = pat[i];
         if (!pat[i]) chk("lit_bp_stall_head", dout, 64'hB2);
         step();
      end
      out_rdy = 1'b0;
      chk("lit_bp_rdone", rd_done, 1);
      chk("lit_bp_n",     obs.size(), 3);
      chk("lit_bp_w2",    obs_at(2), 64'hB3);

      // overflow: five plain data words into a four-word slot
      obs.delete();
      grant();
      for (int i = 0; i < 4; i++) put(64'hC1 + 64'(i), 8'h00);
      chk("lit_ovf_trunc", trunc, 1);
      chk("lit_ovf_done",  wr_done, 1);
      chk("lit_ovf_rdy",   in_rdy, 0);
      chk("lit_ovf_full",  full, 1);
      chk("lit_ovf_count", word_count, 4);
      put(64'hC5, 8'h00);
      chk("lit_ovf_drop",  word_count, 4);
      drain(4);
      chk("lit_ovf_rdone", rd_done, 1);
      chk("lit_ovf_n",     obs.size(), 4);
      chk("lit_ovf_w3",    obs_at(3), 64'hC4);

      // ignored requests
      r0 = n_rd_ack_seen;
      rd_req = 1'b1;
      step(10);
      rd_req = 1'b0;
      chk("lit_ign_rdack", n_rd_ack_seen - r0, 0);
      chk("lit_ign_pckt",  pckt_rd_wr, 1);
      grant();
      put(64'hD1, 8'h00);
      put(64'hD2, 8'h05);
      chk("lit_ign_count", word_count, 2);
      w0 = n_wr_ack_seen;
      wr_req = 1'b1;
      step(10);
      wr_req = 1'b0;
      chk("lit_ign_wrack", n_wr_ack_seen - w0, 0);
      chk("lit_ign_hold",  pckt_rd_wr, 0);
      drain(2);
      chk("lit_ign_rdone", rd_done, 1);

      // simultaneous requests in EMPTY, then reset in the middle of the packet
      wr_req = 1'b1;
      rd_req = 1'b1;
      step();
      wr_req = 1'b0;
      rd_req = 1'b0;
      chk("lit_sim_wrack", wr_ack, 1);
      chk("lit_sim_rdack", rd_ack, 0);
      put(64'hE1, 8'hFF);
      put(64'hE2, 8'h00);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("lit_mrst_count", word_count, 0);
      chk("lit_mrst_pckt",  pckt_rd_wr, 1);
      chk("lit_mrst_rdy",   in_rdy, 0);
      obs.delete();
      grant();
      chk("lit_mrst_ack", wr_ack, 1);
      put(64'hF1, 8'h00);
      put(64'hF2, 8'h01);
      chk("lit_mrst_done", wr_done, 1);
      drain(2);
      chk("lit_mrst_w0", obs_at(0), 64'hF1);

      // held write request
      w0 = n_wr_ack_seen;
      wr_req = 1'b1;
      step(6);
      wr_req = 1'b0;
      chk("lit_held_acks", n_wr_ack_seen - w0, 1);
      put(64'h91, 8'h00);
      put(64'h92, 8'h01);
      drain(2);
      chk("lit_held_rdone", rd_done, 1);
      step(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
